// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, TX mux select codes and parity type constants.
// Used by uart_tx_ctrl and uart_parity_calc; parity logic is gated by UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef struct packed {
    logic [1:0] mux;
    logic       ser_en;
    logic       busy;
  } tx_out_t;

  // Moore output decode; STOP drops busy so the serializer can reload during the stop bit
  function automatic tx_out_t state_outputs(input uart_tx_state_t st);
    tx_out_t o;
    o = '{mux: MUX_STOP, ser_en: 1'b0, busy: 1'b0};
    case (st)
      IDLE:    o = '{mux: MUX_STOP,  ser_en: 1'b0, busy: 1'b0};
      START:   o = '{mux: MUX_START, ser_en: 1'b0, busy: 1'b1};
      DATA:    o = '{mux: MUX_DATA,  ser_en: 1'b1, busy: 1'b1};
      PARITY:  o = '{mux: MUX_PAR,   ser_en: 1'b0, busy: 1'b1};
      STOP:    o = '{mux: MUX_STOP,  ser_en: 1'b0, busy: 1'b0};
      default: o = '{mux: MUX_STOP,  ser_en: 1'b0, busy: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: XOR reduction of the payload, inverted for odd parity.
// Shared between the TX controller and the RX checker.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, data, optional parity and stop slots, one slot per bit clock.
// Build with UART_TX_PARITY_EN defined to include the parity slot and parity bit register.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Ser_Done,
  output logic                  Ser_Enable,
  output logic [1:0]            Mux_Sel,
  output logic                  Par_Bit,
  output logic                  Busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  uart_tx_state_t   state_r;
  uart_tx_state_t   next_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic             accept_s;
  logic             wd_expire_s;
  logic             data_end_s;
  logic             par_en_s;
  tx_out_t          next_out_s;

  assign accept_s    = Data_Valid && !Busy;
  assign wd_expire_s = (bit_cnt_r == CNT_W'(DATA_WIDTH - 1));
  assign data_end_s  = Ser_Done || wd_expire_s;

`ifdef UART_TX_PARITY_EN
  logic par_en_r;
  logic par_bit_r;
  logic par_calc_s;

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (P_Data),
    .par_typ (PAR_TYP),
    .par_bit (par_calc_s)
  );

  // Parity enable and parity bit are captured on accept and held until the next one
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
    end else if (accept_s) begin
      par_en_r  <= PAR_EN;
      par_bit_r <= par_calc_s;
    end else begin
      par_en_r  <= par_en_r;
      par_bit_r <= par_bit_r;
    end
  end

  assign par_en_s = par_en_r;
  assign Par_Bit  = par_bit_r;
`else
  logic unused_par_s;

  assign unused_par_s = ^{P_Data, PAR_EN, PAR_TYP};
  assign par_en_s     = 1'b0;
  assign Par_Bit      = 1'b0;
`endif

  // Next-state logic; the watchdog stands in for a missing Ser_Done on the last data bit
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_s = START;
        else          next_s = IDLE;
      end
      START: next_s = DATA;
      DATA: begin
        if (data_end_s) begin
          if (par_en_s) next_s = PARITY;
          else          next_s = STOP;
        end else begin
          next_s = DATA;
        end
      end
      PARITY: next_s = STOP;
      STOP: begin
        if (accept_s) next_s = START;
        else          next_s = IDLE;
      end
      default: next_s = IDLE;
    endcase
  end

  assign next_out_s = state_outputs(next_s);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_r <= IDLE;
    else     state_r <= next_s;
  end

  // Data-bit watchdog: zero on the first DATA cycle, counts each further DATA cycle
  always_ff @(posedge CLK) begin
    if (RST)                  bit_cnt_r <= '0;
    else if (state_r != DATA) bit_cnt_r <= '0;
    else                      bit_cnt_r <= bit_cnt_r + CNT_W'(1);
  end

  // Outputs are registered from the next-state decode so they line up with the state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      Mux_Sel    <= MUX_STOP;
      Ser_Enable <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      Mux_Sel    <= next_out_s.mux;
      Ser_Enable <= next_out_s.ser_en;
      Busy       <= next_out_s.busy;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: per-cycle expectations are queued when frames are
// requested and compared by a monitor one step after every rising edge.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_BUILT = 1'b1;
`else
  localparam bit PARITY_BUILT = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_Data;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          Ser_Done = 1'b0;
  logic          Ser_Enable;
  logic [1:0]    Mux_Sel;
  logic          Par_Bit;
  logic          Busy;

  typedef struct packed {
    logic [1:0] mux;
    logic       en;
    logic       busy;
    logic       par;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic exp_par_m = 1'b0;
  int   sd_at   = DW - 1;
  int   ser_cnt = 0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_Data     (P_Data),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Ser_Done   (Ser_Done),
    .Ser_Enable (Ser_Enable),
    .Mux_Sel    (Mux_Sel),
    .Par_Bit    (Par_Bit),
    .Busy       (Busy)
  );

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Serializer model: raises Ser_Done on data cycle index sd_at (never when sd_at < 0)
  always @(negedge CLK) begin
    if (Ser_Enable === 1'b1) begin
      Ser_Done = (ser_cnt == sd_at);
      ser_cnt++;
    end else begin
      Ser_Done = 1'b0;
      ser_cnt  = 0;
    end
  end

  // Monitor: one queued expectation per cycle
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mux_sel",    Mux_Sel,             e.mux);
      check("ser_enable", {1'b0, Ser_Enable},  {1'b0, e.en});
      check("busy",       {1'b0, Busy},        {1'b0, e.busy});
      check("par_bit",    {1'b0, Par_Bit},     {1'b0, e.par});
    end
  end

  task automatic push_st(input logic [1:0] mux, input logic en, input logic busy, input int n);
    exp_t e;
    e.mux  = mux;
    e.en   = en;
    e.busy = busy;
    e.par  = exp_par_m;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt, input int dlen);
    exp_par_m = PARITY_BUILT ? ((^d) ^ pt) : 1'b0;
    push_st(MUX_START, 1'b0, 1'b1, 1);
    push_st(MUX_DATA,  1'b1, 1'b1, dlen);
    if (PARITY_BUILT && pe) push_st(MUX_PAR, 1'b0, 1'b1, 1);
    push_st(MUX_STOP,  1'b0, 1'b0, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0)
    else begin
      failures++;
      $error("FAIL %s_drain observed=%0d expected=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      push_st(MUX_STOP, 1'b0, 1'b0, 1);
      @(negedge CLK);
    end
  endtask

  // Called at a negedge with an empty queue; pulse_at > 0 raises Data_Valid once mid-frame
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt,
                      input int dlen, input int pulse_at, input string tag);
    P_Data     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    push_frame(d, pe, pt, dlen);
    @(negedge CLK);
    Data_Valid = 1'b0;
    if (pulse_at > 0) begin
      repeat (pulse_at) @(negedge CLK);
      Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
    end
    wait_drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    // Reset held with a pending request
    RST        = 1'b1;
    Data_Valid = 1'b1;
    P_Data     = 8'hFF;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    push_st(MUX_STOP, 1'b0, 1'b0, 2);
    repeat (2) @(negedge CLK);
    RST        = 1'b0;
    Data_Valid = 1'b0;
    idle(3);

    send(8'hA5, 1'b1, 1'b0, DW, 3, "a5_even");
    idle(2);
    send(8'h07, 1'b1, 1'b1, DW, 0, "07_odd");
    idle(1);
    send(8'h03, 1'b1, 1'b1, DW, 0, "03_odd");
    idle(1);

    // Back-to-back: Data_Valid held across both frames, second accept lands in STOP
    P_Data     = 8'h55;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b1;
    Data_Valid = 1'b1;
    push_frame(8'h55, 1'b0, 1'b1, DW);
    @(negedge CLK);
    P_Data = 8'hAA;
    push_frame(8'hAA, 1'b0, 1'b1, DW);
    n = 0;
    while (exp_q.size() > DW + 1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    Data_Valid = 1'b0;
    wait_drain("back_to_back");
    idle(2);

    // Watchdog: no Ser_Done at all
    sd_at = -1;
    send(8'h3C, 1'b0, 1'b0, DW, 0, "watchdog");
    idle(1);

    // Early Ser_Done on the third data cycle ends DATA there
    sd_at = 2;
    send(8'hC3, 1'b1, 1'b0, 3, 0, "early_done");
    idle(1);
    sd_at = DW - 1;

    // Reset during the fourth DATA cycle
    P_Data     = 8'h81;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b1;
    Data_Valid = 1'b1;
    exp_par_m  = PARITY_BUILT ? ((^P_Data) ^ PAR_TYP) : 1'b0;
    push_st(MUX_START, 1'b0, 1'b1, 1);
    push_st(MUX_DATA,  1'b1, 1'b1, 4);
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    RST       = 1'b1;
    exp_par_m = 1'b0;
    push_st(MUX_STOP, 1'b0, 1'b0, 1);
    @(negedge CLK);
    RST = 1'b0;
    idle(2);
    send(8'h81, 1'b1, 1'b1, DW, 0, "after_reset");
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
